// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size/state types and size table for the lane aligner
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP
  } aligner_state_e;

  localparam int SIZE_BYTES [4] = '{1, 2, 4, 8};

endpackage

// File: rtl/byte_lane_mask.sv
// rtl/byte_lane_mask.sv - two-beat byte-lane mask plus split/misalign/illegal flags
module byte_lane_mask
  import mem_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic [$clog2(DATA_BYTES)-1:0] off,
  input  mem_size_e                     size,
  output logic [2*DATA_BYTES-1:0]       mask,
  output logic                          split,
  output logic                          misalign,
  output logic                          illegal
);

  always_comb begin
    int nb;
    int o;
    nb       = SIZE_BYTES[size];
    o        = int'(off);
    illegal  = nb > DATA_BYTES;
    split    = (o + nb) > DATA_BYTES;
    misalign = (o & (nb - 1)) != 0;
    mask     = '0;
    for (int i = 0; i < 2 * DATA_BYTES; i++) begin
      mask[i] = (i >= o) && (i < o + nb);
    end
  end

endmodule

// File: rtl/mem_lane_aligner.sv
// rtl/mem_lane_aligner.sv - load/store lane aligner; MEM_MISALIGN_SPLIT_EN enables two-beat misaligned accesses
module mem_lane_aligner
  import mem_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic                    bus_write,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_BYTES-1:0]   bus_be,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [8*DATA_BYTES-1:0] rsp_rdata
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int OFF_W = $clog2(DATA_BYTES);

  aligner_state_e          state, state_nxt;
  logic                    write_q, signed_q, err_q;
  mem_size_e               size_q;
  logic [OFF_W-1:0]        off_q;
  logic [W-1:0]            rd0_q, rd1_q;
  logic [2*DATA_BYTES-1:0] req_mask;
  logic                    req_split, req_misalign, req_illegal, req_fault;
  logic [2*W-1:0]          wdata_shifted;
  logic [W-1:0]            rd_shifted, load_data;
  logic                    sign_fill;

  byte_lane_mask #(.DATA_BYTES(DATA_BYTES)) u_mask (
    .off      (req_addr[OFF_W-1:0]),
    .size     (mem_size_e'(req_size)),
    .mask     (req_mask),
    .split    (req_split),
    .misalign (req_misalign),
    .illegal  (req_illegal)
  );

  assign wdata_shifted = {{W{1'b0}}, req_wdata} << {req_addr[OFF_W-1:0], 3'b000};

`ifdef MEM_MISALIGN_SPLIT_EN
  localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(DATA_BYTES);

  logic                  split_q;
  logic [DATA_BYTES-1:0] be_hi_q;
  logic [W-1:0]          wdata_hi_q;
  logic                  unused_misalign;

  assign req_fault       = req_illegal;
  assign unused_misalign = req_misalign;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      split_q    <= 1'b0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      rd1_q      <= '0;
    end else if (state == IDLE && req_valid) begin
      split_q    <= req_split;
      be_hi_q    <= req_mask[2*DATA_BYTES-1:DATA_BYTES];
      wdata_hi_q <= wdata_shifted[2*W-1:W];
      rd1_q      <= '0;
    end else if (state == BEAT1 && bus_ready) begin
      rd1_q <= bus_rdata;
    end
  end
`else
  logic unused_hi;

  // Anything that would need a second beat cannot be issued in this build.
  assign req_fault = req_illegal | req_misalign | req_split;
  assign rd1_q     = '0;
  assign unused_hi = ^{req_mask[2*DATA_BYTES-1:DATA_BYTES], wdata_shifted[2*W-1:W]};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = req_fault ? RESP : BEAT0;
      BEAT0: if (bus_ready) begin
`ifdef MEM_MISALIGN_SPLIT_EN
        state_nxt = split_q ? BEAT1 : RESP;
`else
        state_nxt = RESP;
`endif
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      BEAT1: if (bus_ready) state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= BYTE;
      off_q     <= '0;
      rd0_q     <= '0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_q   <= req_write;
          signed_q  <= req_signed;
          err_q     <= req_fault;
          size_q    <= mem_size_e'(req_size);
          off_q     <= req_addr[OFF_W-1:0];
          rd0_q     <= '0;
          bus_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          bus_be    <= req_mask[DATA_BYTES-1:0];
          bus_wdata <= wdata_shifted[W-1:0];
        end
        BEAT0: if (bus_ready) begin
          rd0_q <= bus_rdata;
`ifdef MEM_MISALIGN_SPLIT_EN
          if (split_q) begin
            bus_addr  <= bus_addr + BEAT_STRIDE;
            bus_be    <= be_hi_q;
            bus_wdata <= wdata_hi_q;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Loads: bring the addressed byte to lane 0, keep nbytes, extend the rest.
  always_comb begin
    int nb;
    nb         = SIZE_BYTES[size_q];
    rd_shifted = W'({rd1_q, rd0_q} >> {off_q, 3'b000});
    sign_fill  = 1'b0;
    load_data  = '0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (b == nb - 1) sign_fill = signed_q & rd_shifted[8*b+7];
    end
    for (int b = 0; b < DATA_BYTES; b++) begin
      load_data[8*b +: 8] = (b < nb) ? rd_shifted[8*b +: 8] : {8{sign_fill}};
    end
  end

  assign req_ready = (state == IDLE);
  assign bus_valid = (state == BEAT0) || (state == BEAT1);
  assign bus_write = bus_valid & write_q;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? load_data : '0;

endmodule

// File: doc/mem_lane_aligner.md
# mem_lane_aligner

Parametrised load/store alignment engine between the core's memory stage and the data bus. Generalises byte-enable generation to any power-of-two bus width. Owns write-data lane steering, read-data extraction with sign/zero extension, and misaligned accesses: it splits them into two bus beats or faults them, depending on build configuration. Holds one request at a time, with a valid/ready request port, a valid/ready bus port, and a single-cycle response pulse.

## Interface
Parameters:
- DATA_BYTES, 4, bus width in bytes; power of two, ≥2.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  engine idle, can accept.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  8*DATA_BYTES  store data, right-justified.
- bus_valid  out  1  bus beat offered.
- bus_ready  in  1  beat accepted; for reads, bus_rdata is valid in the same cycle.
- bus_write  out  1  beat direction.
- bus_addr  out  ADDR_W  beat address, aligned to DATA_BYTES.
- bus_be  out  DATA_BYTES  byte enables.
- bus_wdata  out  8*DATA_BYTES  lane-steered store data.
- bus_rdata  in  8*DATA_BYTES  read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  fault; qualified by rsp_valid.
- rsp_rdata  out  8*DATA_BYTES  load result, extended; 0 for stores and faults.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields.
  - Legal access: go to BEAT0.
  - Fault: go to RESP with err=1. No bus beat is issued.
- Derived values:
  - nbytes = 1<<req_size.
  - off = addr mod DATA_BYTES.
  - mask = ((1<<nbytes)-1) << off, 2*DATA_BYTES bits wide.
  - split = (off+nbytes > DATA_BYTES).
- Illegal size: nbytes > DATA_BYTES always faults.
- BEAT0: bus_valid=1, bus_addr = addr with low bits cleared, bus_be = mask[DATA_BYTES-1:0].
  - bus_wdata = low half of ({DATA_BYTES zero bytes, wdata} << 8*off).
  - On bus_ready: capture bus_rdata as rd0. Go to BEAT1 if split, else RESP.
- BEAT1: bus_addr = beat0 address + DATA_BYTES, bus_be = upper half of mask, bus_wdata = upper half of the shifted data.
  - On bus_ready: capture rd1 and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Load result = ({rd1, rd0} >> 8*off), truncated to nbytes, then zero- or sign-extended (sign bit = bit 8*nbytes-1).
  - For non-split loads, rd1 is treated as 0.
- While bus_valid=1 and bus_ready=0, every bus_* output holds stable.
- No response backpressure; the consumer must take rsp_* in the pulse cycle.

## Timing
- Reset values: req_ready=1, bus_valid=0, bus_write=0, bus_addr=0, bus_be=0, bus_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; state IDLE.
- Reset while busy: the in-flight beat is abandoned. bus_valid=0 from the next edge and no response is produced.
- Latency, measured from the accept edge (cycle 0) with zero bus wait states:
  - Aligned: bus_valid in cycle 1, rsp_valid in cycle 2.
  - Split: beats in cycles 1–2, rsp_valid in cycle 3.
  - Fault: rsp_valid in cycle 1.
- Each bus wait cycle adds one cycle of latency.
- Throughput: one request per 3 cycles minimum. req_ready=0 outside IDLE.

## Configuration
- MEM_MISALIGN_SPLIT_EN defined: misaligned legal-size accesses are split into two beats as above.
- MEM_MISALIGN_SPLIT_EN undefined: any access with off mod nbytes ≠ 0 faults (rsp_err=1, no bus beat). BEAT1 logic and rd1 storage are removed.

## Structure
- Shared package mem_pkg holds:
  - mem_size_e (BYTE/HALF/WORD/DWORD);
  - the aligner_state_e enum;
  - constant SIZE_BYTES lookup.
- One sub-module, byte_lane_mask: combinational; takes off and size, produces the 2*DATA_BYTES mask plus the split and misalign flags. It is reused by the store and load paths.

## Test plan
Scenarios use DATA_BYTES=4.
- Word store, addr 0x100, data 0xDEADBEEF -> single beat at 0x100, be=1111, wdata=0xDEADBEEF; rsp_valid at cycle 2, err=0.
- Byte load, addr 0x103, bus_rdata=0x80123456: signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half store, addr 0x103, data 0xABCD:
  - With the macro: beat0 at 0x100, be=1000, wdata[31:24]=0xCD; beat1 at 0x104, be=0001, wdata[7:0]=0xAB.
  - Without the macro: rsp_err=1, bus_valid never asserts.
- Word load, addr 0x102, rd0=0x3322_1100, rd1=0x7766_5544 -> rsp_rdata=0x55443322, rsp_valid at cycle 3.
- bus_ready held low 5 cycles in BEAT0 -> bus_* outputs stable throughout, then completes. Separately, reset_n=0 during BEAT1 -> bus_valid=0 and req_ready=1 at the next edge, no rsp_valid.
- req_size=3 with DATA_BYTES=4 -> rsp_err=1 at cycle 1, no bus beat.
